// File: rtl/ex_issue_stage.sv
// ex_issue_stage: single-entry issue register between decode and the ALU.
// It holds one instruction and forwards operands from the MEM and WB producers.
// Forwarding priority is MEM, then WB, then the held register-file value.
// It stalls on a load-use hazard and counts those stall cycles.
// While the instruction is stalled, its operands are refreshed each cycle, so a
// value forwarded from WB is still there after WB has moved on.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid/id_ready   upstream handshake; id_* carry the offered instruction
//   flush               drop the held and the offered instruction
//   mem_*, wb_*         producers one and two stages ahead (forwarding sources)
//   ex_ready            downstream accepts this cycle
//   ex_*                ALU operands and controls; ex_valid qualifies them
//   stall_cnt           saturating count of load-use stall cycles
module ex_issue_stage #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         id_valid,
  output logic         id_ready,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [n-1:0] id_rs_val,
  input  logic [n-1:0] id_rt_val,
  input  logic [15:0]  id_imm,
  input  logic         id_sext,
  input  logic [3:0]   id_af,
  input  logic         id_i,
  input  logic [4:0]   id_rd,
  input  logic         id_wr,
  input  logic         flush,
  input  logic         mem_wr,
  input  logic [4:0]   mem_rd,
  input  logic [n-1:0] mem_res,
  input  logic         mem_load,
  input  logic         wb_wr,
  input  logic [4:0]   wb_rd,
  input  logic [n-1:0] wb_res,
  input  logic         ex_ready,
  output logic         ex_valid,
  output logic [n-1:0] ex_a,
  output logic [n-1:0] ex_b,
  output logic [3:0]   ex_af,
  output logic         ex_i,
  output logic [4:0]   ex_rd,
  output logic         ex_wr,
  output logic [15:0]  stall_cnt
);

  localparam int unsigned imm_w = 16;
  localparam int unsigned ext_w = n - imm_w;

  // Held instruction
  logic         v_q;
  logic [4:0]   rs_q, rt_q, rd_q;
  logic [n-1:0] rs_val_q, rt_val_q;
  logic [15:0]  imm_q;
  logic         sext_q, i_q, wr_q;
  logic [3:0]   af_q;

  logic [n-1:0] rs_fwd, rt_fwd, imm_ext;
  logic         luse, capture, consume;

  // Operand forwarding: register 0 is never forwarded; MEM beats WB
  always_comb begin
    rs_fwd = rs_val_q;
    if (rs_q != 5'd0) begin
      if (mem_wr && mem_rd == rs_q)     rs_fwd = mem_res;
      else if (wb_wr && wb_rd == rs_q)  rs_fwd = wb_res;
    end
    rt_fwd = rt_val_q;
    if (rt_q != 5'd0) begin
      if (mem_wr && mem_rd == rt_q)     rt_fwd = mem_res;
      else if (wb_wr && wb_rd == rt_q)  rt_fwd = wb_res;
    end
  end

  assign imm_ext = {{ext_w{sext_q & imm_q[15]}}, imm_q};

  // A load in MEM feeding a source still in use cannot be forwarded yet
  assign luse = v_q && mem_load && mem_wr && (mem_rd != 5'd0) &&
                ((mem_rd == rs_q) || (!i_q && (mem_rd == rt_q)));

  assign ex_valid = v_q && !luse;
  assign ex_a     = rs_fwd;
  assign ex_b     = i_q ? imm_ext : rt_fwd;
  assign ex_af    = af_q;
  assign ex_i     = i_q;
  assign ex_rd    = rd_q;
  assign ex_wr    = wr_q;
  assign id_ready = !v_q || (ex_ready && !luse);

  assign capture = id_valid && id_ready && !flush;
  assign consume = ex_valid && ex_ready;

  // Holding register: flush > capture > consume > operand refresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      sext_q   <= 1'b0;
      i_q      <= 1'b0;
      wr_q     <= 1'b0;
      af_q     <= '0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (capture) begin
      v_q      <= 1'b1;
      rs_q     <= id_rs;
      rt_q     <= id_rt;
      rd_q     <= id_rd;
      rs_val_q <= id_rs_val;
      rt_val_q <= id_rt_val;
      imm_q    <= id_imm;
      sext_q   <= id_sext;
      i_q      <= id_i;
      wr_q     <= id_wr;
      af_q     <= id_af;
    end else if (consume) begin
      v_q <= 1'b0;
    end else if (v_q) begin
      rs_val_q <= rs_fwd;
      rt_val_q <= rt_fwd;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (luse && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 SHALL have parameter n, default 32, datapath width of operands and results.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_valid input 1 / id_ready output 1: upstream valid/ready handshake.
REQ-005 SHALL have inputs id_rs, id_rt (5 each): source register numbers.
REQ-006 SHALL have inputs id_rs_val, id_rt_val (n each): register-file read values.
REQ-007 SHALL have inputs id_imm (16), id_sext (1), id_af (4), id_i (1), id_rd (5), id_wr (1): immediate, sign-extend select, ALU function, immediate-type flag, destination, write-enable.
REQ-008 SHALL have input flush (1): discard held and incoming instruction.
REQ-009 SHALL have inputs mem_wr (1), mem_rd (5), mem_res (n), mem_load (1): producer one stage ahead.
REQ-010 SHALL have inputs wb_wr (1), wb_rd (5), wb_res (n): producer two stages ahead.
REQ-011 SHALL have input ex_ready (1): downstream accepts this cycle.
REQ-012 SHALL have outputs ex_valid (1), ex_a (n), ex_b (n), ex_af (4), ex_i (1), ex_rd (5), ex_wr (1): operands and controls for the ALU.
REQ-013 SHALL have output stall_cnt (16): saturating count of load-use stall cycles.

Function
REQ-014 SHALL hold one instruction in a register set: v, rs, rt, rs_val, rt_val, imm, sext, af, i, rd, wr.
REQ-015 SHALL define fwd(r, val): r==0 -> val; mem_wr && mem_rd==r -> mem_res; else wb_wr && wb_rd==r -> wb_res; else val (MEM beats WB).
REQ-016 SHALL drive ex_a = fwd(rs, rs_val) combinationally from held state.
REQ-017 SHALL drive ex_b = i ? ext(imm) : fwd(rt, rt_val); ext = sext ? 16 copies of imm[15] : 16 zeros, above imm.
REQ-018 SHALL compute luse = v && mem_load && mem_wr && mem_rd!=0 && (mem_rd==rs || (!i && mem_rd==rt)).
REQ-019 SHALL drive ex_valid = v && !luse; ex_af, ex_i, ex_rd, ex_wr straight from held state.
REQ-020 SHALL drive id_ready = !v || (ex_ready && !luse) (combinational, no dependence on id_valid).
REQ-021 SHALL capture id_* on an edge with id_valid && id_ready && !flush, setting v=1.
REQ-022 SHALL clear v on an edge with ex_valid && ex_ready and no capture.
REQ-023 SHALL, when v && !(ex_valid && ex_ready), overwrite rs_val/rt_val with their fwd() values each edge (operand refresh, so WB-forwarded data survives stalls).
REQ-024 SHALL on flush clear v at the next edge, dropping held and offered instruction; flush beats capture; id_ready unaffected.
REQ-025 SHALL increment stall_cnt on each edge where luse==1, saturating at 16'hFFFF (no wrap).
REQ-026 SHALL add one cycle latency: instruction accepted at edge k presented with ex_valid from edge k to its consumption.
REQ-027 SHALL support full throughput: consume and capture on same edge when ex_ready && id_valid.

Reset
REQ-028 SHALL on rst_n low immediately clear v, all held fields and stall_cnt to 0 regardless of clk.
REQ-029 SHALL during and after reset present ex_valid=0, ex_a=0, ex_b=0, ex_af=0, ex_i=0, ex_rd=0, ex_wr=0, id_ready=1 (with fwd inputs 0).
REQ-030 SHALL discard an instruction mid-stall on reset; first capture after deassertion behaves as from idle.

Verification
REQ-031 Back-to-back: id_valid=1, ex_ready=1, 4 instrs -> one per cycle on ex_*, id_ready stays 1, stall_cnt=0.
REQ-032 Forward priority: held rs=5, mem_wr=1 mem_rd=5 mem_res=0xAAAA, wb_wr=1 wb_rd=5 wb_res=0xBBBB -> ex_a=0xAAAA; rs=0 with same -> ex_a=rs_val.
REQ-033 Immediate: id_i=1, id_imm=0x8001, id_sext=1 -> ex_b=0xFFFF8001; id_sext=0 -> ex_b=0x00008001; rt match on MEM ignored.
REQ-034 Load-use: held rs=3, mem_load=1 mem_wr=1 mem_rd=3 for 2 cycles -> ex_valid=0, id_ready=0 for 2 cycles, stall_cnt=2, then ex_valid=1.
REQ-035 Refresh: ex_ready=0, wb_wr=1 wb_rd=rt wb_res=0x1234 one cycle then wb_wr=0 -> ex_b stays 0x1234.
REQ-036 Flush/reset: flush with id_valid=1 and v=1 -> next cycle ex_valid=0; rst_n low mid-stall -> ex_valid=0, stall_cnt=0 immediately.
